// File: rtl/intadd_acc_reduce.sv
// Streaming saturating-add reduction: folds a burst of 32-bit elements
// into one accumulator and returns it over a valid/ready handshake.
module intadd_acc_reduce #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [31:0]      cfg_init,
    input  logic             sign_s0,
    input  logic             sign_s1,
    input  logic             i_sign_d,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    logic [31:0]      acc;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             sat_q;
    logic             mode_q;
    logic [32:0]      step;
    logic             last;

    // Returns {saturated, clamped_sum}.
    function automatic logic [32:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sgn
    );
        logic [32:0] s;
        logic [32:0] r;
        s = {sgn & a[31], a} + {sgn & b[31], b};
        r = {1'b0, s[31:0]};
        if (sgn) begin
            unique case (s[32:31])
                2'b10:   r = {1'b1, 32'h8000_0000};
                2'b01:   r = {1'b1, 32'h7FFF_FFFF};
                default: r = {1'b0, s[31:0]};
            endcase
        end else if (s[32]) begin
            r = {1'b1, 32'hFFFF_FFFF};
        end
        return r;
    endfunction

    assign step     = sat_add(acc, in_data, mode_q);
    assign last     = (count == len_q - LEN_W'(1));
    assign out_data = acc;
    assign out_sat  = sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            sat_q     <= 1'b0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        acc    <= cfg_init;
                        len_q  <= cfg_len;
                        count  <= '0;
                        sat_q  <= 1'b0;
                        mode_q <= sign_s0 | sign_s1 | i_sign_d;
                        busy   <= 1'b1;
                        if (cfg_len != '0) begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc   <= step[31:0];
                        sat_q <= sat_q | step[32];
                        count <= count + LEN_W'(1);
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start arriving with the handshake is dropped.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
